// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a req/gnt/rvalid data-memory port.
//
// Purpose:
//   Takes the EX/MEM slot, issues loads and stores to a data memory with a
//   request/grant handshake plus a separate read-valid return, formats store
//   byte enables/data and load extension, and registers the MEM/WB slot.
//   Upstream stages are frozen through 'stall' while an access is pending.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in                 EX/MEM slot holds a valid instruction
//   cw_mem[4:0]              bit0 mem_rd, bit1 mem_wr, bits[4:2] funct3
//   cw_wb_in[2:0]            WB control word, passed through
//   ALUres_in, store_data,   address/result, store data, next PC
//   NPCin
//   regDest_in[4:0]          destination register
//   dmem_req/we/addr/wdata/be  request side of the data-memory port
//   dmem_gnt, dmem_rvalid,   grant, read-valid and read data from memory
//   dmem_rdata
//   cw_wb, ALUres, MEMread,  MEM/WB register outputs
//   NPCout, regDest
//   stall                    freezes upstream while an access is pending
//   misalign                 registered misaligned-access trap flag
//
// Configuration:
//   MEM_MISALIGN_CHECK_EN    when defined, misaligned halfword/word accesses
//                            are trapped (no request, misalign = 1, bubble).
//                            When undefined, misalign is 0 and the offending
//                            low address bits are ignored for lane selection.
//
// N is expected to be a multiple of 16 (32 in practice).

module mem_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [4:0]   cw_mem,
    input  logic [2:0]   cw_wb_in,
    input  logic [N-1:0] ALUres_in,
    input  logic [N-1:0] store_data,
    input  logic [N-1:0] NPCin,
    input  logic [4:0]   regDest_in,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [N-1:0] dmem_wdata,
    output logic [3:0]   dmem_be,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [N-1:0] dmem_rdata,
    output logic [2:0]   cw_wb,
    output logic [N-1:0] ALUres,
    output logic [N-1:0] MEMread,
    output logic [N-1:0] NPCout,
    output logic [4:0]   regDest,
    output logic         stall,
    output logic         misalign
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_t;

    state_t state_reg;

    // Request fields captured at issue so they stay stable while waiting.
    logic [N-1:0] addr_reg;
    logic [N-1:0] wdata_reg;
    logic [3:0]   be_reg;
    logic         we_reg;
    logic [1:0]   off_reg;
    logic [2:0]   f3_reg;

    // MEM/WB register
    logic [2:0]   cw_wb_reg;
    logic [N-1:0] alures_reg;
    logic [N-1:0] memread_reg;
    logic [N-1:0] npc_reg;
    logic [4:0]   regdest_reg;

    // Instruction decode
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] funct3;
    logic [1:0] size;       // 00 byte, 01 half, 1x word
    logic [1:0] raw_off;
    logic [1:0] eff_off;    // lane offset with meaningless low bits dropped
    logic       is_mem;
    logic       misalign_detect;

    assign mem_rd  = cw_mem[0];
    assign mem_wr  = cw_mem[1];
    assign funct3  = cw_mem[4:2];
    assign size    = funct3[1:0];
    assign raw_off = ALUres_in[1:0];
    assign is_mem  = valid_in & (mem_rd | mem_wr);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_detect = is_mem &
                             (((size == 2'b01) & raw_off[0]) |
                              (size[1] & (raw_off != 2'b00)));
`else
    assign misalign_detect = 1'b0;
`endif

    always_comb begin
        eff_off = 2'b00;
        case (size)
            2'b00:   eff_off = raw_off;
            2'b01:   eff_off = {raw_off[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    // Store data lane replication
    logic [N-1:0] byte_rep;
    logic [N-1:0] half_rep;

    genvar gi;
    generate
        for (gi = 0; gi < N / 8; gi++) begin : g_byte_rep
            assign byte_rep[8*gi +: 8] = store_data[7:0];
        end
        for (gi = 0; gi < N / 16; gi++) begin : g_half_rep
            assign half_rep[16*gi +: 16] = store_data[15:0];
        end
    endgenerate

    logic [3:0]   new_be;
    logic [N-1:0] new_wdata;

    always_comb begin
        new_be    = 4'b1111;
        new_wdata = store_data;
        case (size)
            2'b00: begin
                new_be    = 4'b0001 << eff_off;
                new_wdata = byte_rep;
            end
            2'b01: begin
                new_be    = 4'b0011 << eff_off;
                new_wdata = half_rep;
            end
            default: begin
                new_be    = 4'b1111;
                new_wdata = store_data;
            end
        endcase
    end

    // Handshake bookkeeping
    logic issue;
    logic store_done;
    logic load_done;
    logic pending;
    logic stall_int;
    logic load_wb;

    assign issue      = (state_reg == IDLE) & is_mem & ~misalign_detect;
    assign store_done = dmem_gnt &
                        ((issue & mem_wr) | ((state_reg == WAIT_GNT) & we_reg));
    // rvalid is only honoured in WAIT_RVALID, so a beat coinciding with the
    // grant (or arriving after a reset abandoned the access) is dropped.
    assign load_done  = (state_reg == WAIT_RVALID) & dmem_rvalid;
    assign pending    = issue | (state_reg != IDLE);
    assign stall_int  = pending & ~(store_done | load_done);
    assign load_wb    = ((state_reg == IDLE) & valid_in & ~is_mem) |
                        store_done | load_done;

    assign stall = stall_int & ~rst;

    // Request port: live decode in IDLE, captured fields while waiting.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = we_reg;
        dmem_addr  = addr_reg;
        dmem_be    = be_reg;
        dmem_wdata = wdata_reg;
        case (state_reg)
            IDLE: begin
                dmem_req   = issue;
                dmem_we    = mem_wr;
                dmem_addr  = {ALUres_in[N-1:2], 2'b00};
                dmem_be    = new_be;
                dmem_wdata = new_wdata;
            end
            WAIT_GNT: dmem_req = 1'b1;
            default:  dmem_req = 1'b0;
        endcase
        if (rst) begin
            dmem_req = 1'b0;
        end
    end

    // Load lane extraction and extension, using the captured offset/funct3
    logic [7:0]   byte_lane;
    logic [15:0]  half_lane;
    logic [N-1:0] load_ext;

    assign byte_lane = dmem_rdata[{off_reg, 3'b000} +: 8];
    assign half_lane = dmem_rdata[{off_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem_rdata;
        case (f3_reg)
            3'b000:  load_ext = {{(N-8){byte_lane[7]}}, byte_lane};
            3'b100:  load_ext = {{(N-8){1'b0}}, byte_lane};
            3'b001:  load_ext = {{(N-16){half_lane[15]}}, half_lane};
            3'b101:  load_ext = {{(N-16){1'b0}}, half_lane};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            we_reg      <= 1'b0;
            off_reg     <= '0;
            f3_reg      <= '0;
            cw_wb_reg   <= '0;
            alures_reg  <= '0;
            memread_reg <= '0;
            npc_reg     <= '0;
            regdest_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        addr_reg  <= {ALUres_in[N-1:2], 2'b00};
                        wdata_reg <= new_wdata;
                        be_reg    <= new_be;
                        we_reg    <= mem_wr;
                        off_reg   <= eff_off;
                        f3_reg    <= funct3;
                        if (!dmem_gnt) begin
                            state_reg <= WAIT_GNT;
                        end else if (!mem_wr) begin
                            state_reg <= WAIT_RVALID;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (dmem_gnt) begin
                        state_reg <= we_reg ? IDLE : WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (dmem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Completion loads the slot; anything else (stall, bubble,
            // trapped access) only kills the WB control word.
            if (load_wb) begin
                cw_wb_reg   <= cw_wb_in;
                alures_reg  <= ALUres_in;
                memread_reg <= load_done ? load_ext : '0;
                npc_reg     <= NPCin;
                regdest_reg <= regDest_in;
            end else begin
                cw_wb_reg   <= '0;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (state_reg == IDLE) & misalign_detect;
        end
    end

    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    assign cw_wb   = cw_wb_reg;
    assign ALUres  = alures_reg;
    assign MEMread = memread_reg;
    assign NPCout  = npc_reg;
    assign regDest = regdest_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// A transaction-level model plans each instruction's memory timing (grant
// delay, rvalid delay) and derives from it the expected request/stall values
// per cycle and the MEM/WB contents after each edge. One negedge process
// compares the DUT with those expectations; a few literal checks pin the
// directed scenarios.

module tb_mem_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [4:0]   cw_mem;
    logic [2:0]   cw_wb_in;
    logic [N-1:0] ALUres_in;
    logic [N-1:0] store_data;
    logic [N-1:0] NPCin;
    logic [4:0]   regDest_in;
    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [N-1:0] dmem_rdata;
    logic [2:0]   cw_wb;
    logic [N-1:0] ALUres;
    logic [N-1:0] MEMread;
    logic [N-1:0] NPCout;
    logic [4:0]   regDest;
    logic         stall;
    logic         misalign;

    mem_stage #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .cw_mem     (cw_mem),
        .cw_wb_in   (cw_wb_in),
        .ALUres_in  (ALUres_in),
        .store_data (store_data),
        .NPCin      (NPCin),
        .regDest_in (regDest_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .cw_wb      (cw_wb),
        .ALUres     (ALUres),
        .MEMread    (MEMread),
        .NPCout     (NPCout),
        .regDest    (regDest),
        .stall      (stall),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    // Expected combinational values for the current cycle
    logic        e_req, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    // Expected MEM/WB register contents
    logic [2:0]  m_cw;
    logic [31:0] m_alu, m_mem, m_npc;
    logic [4:0]  m_rd;
    logic        m_mis;

    int errors = 0;
    int checks = 0;
    int stall_seen, req_seen, txn_id;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Single per-cycle compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            if (e_req) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
                if (e_we) begin
                    chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
                    chk("dmem_wdata", dmem_wdata, e_wdata);
                end
            end
            chk("cw_wb", {29'd0, cw_wb}, {29'd0, m_cw});
            chk("ALUres", ALUres, m_alu);
            chk("MEMread", MEMread, m_mem);
            chk("NPCout", NPCout, m_npc);
            chk("regDest", {27'd0, regDest}, {27'd0, m_rd});
            chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
            if (stall) stall_seen++;
            if (dmem_req) begin
                req_seen++;
                last_addr  = dmem_addr;
                last_wdata = dmem_wdata;
                last_be    = dmem_be;
            end
        end
    end

    // ---------------- behavioural model helpers ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1]) return 2;
        if (f3[0]) return 1;
        return 0;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        int sz = size_of(f3);
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        if (sz == 0) return int'(a % 4);
        if (sz == 1) return int'(a % 4) & 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int off = lane_off(f3, a);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(f3);
        if (sz == 0) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rd);
        logic [31:0] w, v;
        w = rd >> (8 * off);
        case (size_of(f3))
            0: begin
                v = w & 32'hFF;
                if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            1: begin
                v = w & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Advance one clock and update the expected MEM/WB slot.
    task automatic tick(input bit done, input logic [2:0] cw, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] npc,
                        input logic [4:0] rd, input bit mis);
        @(posedge clk);
        #1;
        if (done) begin
            m_cw  = cw;
            m_alu = alu;
            m_mem = mem;
            m_npc = npc;
            m_rd  = rd;
        end else begin
            m_cw = 3'd0;
        end
        m_mis = mis;
    endtask

    // Run one instruction: g = cycles without grant, r = cycles from grant to rvalid.
    task automatic do_instr(input bit valid, input logic [4:0] cwm, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [31:0] npc,
                            input logic [4:0] rd, input logic [2:0] cwwb,
                            input int g, input int r, input logic [31:0] rdata);
        logic [2:0] f3;
        bit mem_op, st, mis;
        f3     = cwm[4:2];
        mem_op = valid && (cwm[0] || cwm[1]);
        st     = cwm[1];
        mis    = mem_op && is_misaligned(f3, alu);
        stall_seen = 0;
        req_seen   = 0;
        valid_in   = valid;
        cw_mem     = cwm;
        ALUres_in  = alu;
        store_data = sd;
        NPCin      = npc;
        regDest_in = rd;
        cw_wb_in   = cwwb;
        e_addr  = {alu[31:2], 2'b00};
        e_we    = st;
        e_be    = exp_be(f3, alu);
        e_wdata = exp_wdata(f3, sd);
        if (!mem_op || mis) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            e_req = 1'b0; e_stall = 1'b0;
            tick(valid && !mem_op, cwwb, alu, 32'd0, npc, rd, mis);
        end else if (st) begin
            for (int k = 0; k <= g; k++) begin
                dmem_gnt = (k == g); dmem_rvalid = 1'b0;
                e_req = 1'b1; e_stall = (k < g);
                tick(k == g, cwwb, alu, 32'd0, npc, rd, 1'b0);
            end
        end else begin
            for (int k = 0; k <= g; k++) begin
                dmem_gnt    = (k == g);
                dmem_rvalid = (k == g) ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem_rdata  = $urandom;
                e_req = 1'b1; e_stall = 1'b1;
                tick(1'b0, cwwb, alu, 32'd0, npc, rd, 1'b0);
            end
            for (int j = 1; j <= r; j++) begin
                dmem_gnt    = 1'b0;
                dmem_rvalid = (j == r);
                dmem_rdata  = (j == r) ? rdata : $urandom;
                e_req = 1'b0; e_stall = (j < r);
                tick(j == r, cwwb, alu, exp_load(f3, lane_off(f3, alu), rdata), npc, rd, 1'b0);
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        $display("txn %0d: valid=%0d cw_mem=%b addr=%h gnt_dly=%0d rv_dly=%0d stalls=%0d",
                 txn_id, valid, cwm, alu, g, r, stall_seen);
        txn_id++;
    endtask

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        txn_id = 0;
        // Reset with a load sitting in the slot: no request, no stall.
        rst = 1'b1;
        valid_in = 1'b1; cw_mem = 5'b01001; cw_wb_in = 3'b111;
        ALUres_in = 32'h100; store_data = 32'h0; NPCin = 32'h4; regDest_in = 5'd1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        m_cw = '0; m_alu = '0; m_mem = '0; m_npc = '0; m_rd = '0; m_mis = 1'b0;
        e_req = 1'b0; e_stall = 1'b0; e_we = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0;
        chk_en = 1'b1;
        tick(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        tick(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        // Non-memory instruction
        do_instr(1'b1, 5'b00000, 32'h55, 32'h0, 32'h1004, 5'd3, 3'b101, 0, 1, 32'h0);
        chk("alu_passthrough", ALUres, 32'h55);

        // LW, immediate grant, rvalid one cycle later
        do_instr(1'b1, 5'b01001, 32'h100, 32'h0, 32'h1008, 5'd5, 3'b011, 0, 1, 32'hDEAD_BEEF);
        chk("lw_memread", MEMread, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", stall_seen, 1);

        // LB / LBU from the top byte
        do_instr(1'b1, 5'b00001, 32'h103, 32'h0, 32'h100C, 5'd6, 3'b011, 0, 1, 32'h80FF_FFFF);
        chk("lb_memread", MEMread, 32'hFFFF_FF80);
        do_instr(1'b1, 5'b10001, 32'h103, 32'h0, 32'h1010, 5'd7, 3'b011, 0, 1, 32'h80FF_FFFF);
        chk("lbu_memread", MEMread, 32'h0000_0080);

        // SH to the upper half
        do_instr(1'b1, 5'b00110, 32'h102, 32'h1234, 32'h1014, 5'd0, 3'b000, 0, 1, 32'h0);
        chk("sh_be", {28'd0, last_be}, 32'h0000_000C);
        chk("sh_wdata", last_wdata, 32'h1234_1234);
        chk("sh_addr", last_addr, 32'h100);

        // SW with a 3-cycle grant delay
        do_instr(1'b1, 5'b01010, 32'h204, 32'hCAFE_F00D, 32'h1018, 5'd0, 3'b000, 3, 1, 32'h0);
        chk("sw_stall_cycles", stall_seen, 3);
        chk("sw_req_cycles", req_seen, 4);
        chk("sw_wdata", last_wdata, 32'hCAFE_F00D);

        // LW at a misaligned address
        do_instr(1'b1, 5'b01001, 32'h102, 32'h0, 32'h101C, 5'd9, 3'b011, 0, 1, 32'hA5A5_0F0F);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_no_req", req_seen, 0);
        chk("mis_bubble", {29'd0, cw_wb}, 32'd0);
`else
        chk("unal_req_cycles", req_seen, 1);
        chk("unal_addr", last_addr, 32'h100);
        chk("unal_memread", MEMread, 32'hA5A5_0F0F);
`endif

        // Reset while waiting for rvalid
        valid_in = 1'b1; cw_mem = 5'b01001; cw_wb_in = 3'b110;
        ALUres_in = 32'h300; NPCin = 32'h1020; regDest_in = 5'd11;
        e_addr = 32'h300; e_we = 1'b0; e_req = 1'b1; e_stall = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        tick(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        m_cw = '0; m_alu = '0; m_mem = '0; m_npc = '0; m_rd = '0; m_mis = 1'b0;
        e_req = 1'b0; e_stall = 1'b0;
        #1;
        chk("rst_alures", ALUres, 32'd0);
        chk("rst_memread", MEMread, 32'd0);
        chk("rst_npc", NPCout, 32'd0);
        chk("rst_regdest", {27'd0, regDest}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        tick(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b0;
        valid_in = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        tick(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        dmem_rvalid = 1'b0;
        chk("late_rvalid_memread", MEMread, 32'd0);

        // Randomized traffic, back to back
        for (int t = 0; t < 300; t++) begin
            int kind;
            logic [4:0] cwm;
            logic [2:0] f3;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                cwm = 5'($urandom);
            end else if (kind == 1) begin
                cwm = {3'($urandom), 2'b00};
            end else if (kind <= 5) begin
                f3  = ld_f3[$urandom_range(0, 4)];
                cwm = {f3, 2'b01};
            end else begin
                f3  = 3'($urandom_range(0, 2));
                cwm = {f3, 2'b10};
            end
            do_instr(kind != 0, cwm, $urandom, $urandom, $urandom, 5'($urandom),
                     3'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port valid_in  input  1  EX/MEM slot holds a valid instruction.
REQ-005 SHALL have port cw_mem  input  5  bit0 = mem_rd, bit1 = mem_wr, bits[4:2] = funct3 (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-006 SHALL have port cw_wb_in  input  3  WB control word, passed through.
REQ-007 SHALL have ports ALUres_in, store_data, NPCin  input  N each  address/result, store data, next PC.
REQ-008 SHALL have port regDest_in  input  5  destination register.
REQ-009 SHALL have data memory ports: dmem_req, dmem_we (output 1 each); dmem_addr, dmem_wdata (output N each); dmem_be (output 4); dmem_gnt, dmem_rvalid (input 1 each); dmem_rdata (input N).
REQ-010 SHALL have outputs to WB: cw_wb (3), ALUres (N), MEMread (N), NPCout (N), regDest (5).
REQ-011 SHALL have outputs stall (1, freezes upstream stages) and misalign (1, registered trap flag).

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT_GNT, WAIT_RVALID.
REQ-013 In IDLE with valid_in and mem_rd or mem_wr, dmem_req SHALL assert in the same cycle.
- dmem_addr SHALL be {ALUres_in[N-1:2], 2'b00}.
- dmem_we SHALL equal mem_wr.
REQ-014 Store byte enables and data:
- SB: dmem_be = 0001 << addr[1:0], with the byte replicated across all four lanes.
- SH: dmem_be = 0011 << addr[1:0], with the half replicated across both halves.
- SW: dmem_be = 1111.
REQ-015 A request without dmem_gnt SHALL move to WAIT_GNT, holding dmem_req, address, we, be and wdata stable until the grant.
REQ-016 When a store is granted, the instruction SHALL complete, and the MEM/WB register SHALL load at that edge, giving a store latency of 1 cycle.
REQ-017 When a load is granted, the FSM SHALL move to WAIT_RVALID and SHALL NOT assert dmem_req.
- dmem_rvalid SHALL complete the load in its cycle.
- dmem_rvalid in the grant cycle itself SHALL be ignored.
REQ-018 Load data SHALL be the lane selected by the latched addr[1:0]:
- LB/LH sign-extend to N bits.
- LBU/LHU zero-extend to N bits.
- LW passes the word unchanged.
REQ-019 Non-memory valid instructions SHALL register into MEM/WB with 1-cycle latency and SHALL NOT assert dmem_req.
REQ-020 stall SHALL be 1 in any cycle where a memory operation is pending and not completing (no grant for a store, no rvalid for a load); otherwise stall SHALL be 0.
REQ-021 While stall is 1, MEM/WB SHALL load a bubble: cw_wb = 000, all other outputs unchanged.
REQ-022 valid_in = 0 SHALL register a bubble.
REQ-023 On completion, MEM/WB SHALL load:
- cw_wb_in, ALUres_in, regDest_in and NPCin;
- extended load data into MEMread, or 0 for non-loads.
REQ-024 Back-to-back memory operations SHALL be accepted in IDLE on the cycle after completion, with no idle gap.

Reset
REQ-025 rst SHALL asynchronously force the FSM to IDLE and clear all registered outputs to 0.
REQ-026 dmem_req and stall SHALL be 0 while rst is high.
REQ-027 Reset mid-transaction SHALL abandon the access, and a subsequently arriving dmem_rvalid SHALL be ignored.

Configuration
REQ-028 With macro MEM_MISALIGN_CHECK_EN defined, a misaligned access SHALL suppress dmem_req, register misalign = 1 and register a bubble.
- Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] != 00.
REQ-029 With MEM_MISALIGN_CHECK_EN undefined, misalign SHALL be tied to 0, and the offending low address bits SHALL be treated as 0 for lane selection.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- LW: ALUres_in = 0x100, gnt immediate, rvalid one cycle later with rdata = 0xDEADBEEF -> MEMread = 0xDEADBEEF, stall high for exactly 1 cycle.
- LB: addr = 0x103, rdata = 0x80FF_FFFF -> MEMread = 0xFFFF_FF80.
- LBU: same access as the LB case -> MEMread = 0x0000_0080.
- SH: addr = 0x102, store_data = 0x1234 -> dmem_be = 1100, dmem_wdata = 0x12341234.
- SW with gnt delayed 3 cycles -> request fields stable throughout, stall high for 3 cycles, and 3 bubbles with cw_wb = 000.
- rst asserted during WAIT_RVALID -> IDLE immediately, all outputs 0, late rvalid ignored.
- With MEM_MISALIGN_CHECK_EN defined, LW at addr = 0x102 -> no dmem_req, misalign = 1, cw_wb = 000.
